// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. Synchronises the asynchronous serial line, validates
//   the start bit at mid-bit, samples each data bit at mid-bit (LSB first) and
//   checks the stop bit. A good frame updates rx_data with a one-cycle
//   rx_valid strobe; a low stop bit gives a one-cycle frame_err strobe and
//   the receiver then waits for the line to return high before re-arming.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   rx_in      asynchronous serial input, idle high
//   rx_data    last correctly received word, held until the next good frame
//   rx_valid   one-cycle pulse: rx_data updated this cycle
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state, state_nxt;
    logic                 s1, rx_s;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt;
    logic                 frame_err_nxt;

    // Two-flop synchroniser; both flops reset to the idle (high) level so a
    // reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= rx_in;
            rx_s <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end

            START: begin
                // A low pulse shorter than half a bit is a glitch, not a start.
                if (cnt == CNT_HALF) begin
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        cnt_nxt     = '0;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    // Shift in at the MSB so the first (LSB) bit lands in bit 0.
                    shreg_nxt = (shreg >> 1) |
                                (DATA_BITS'(rx_s) << (DATA_BITS - 1));
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + BW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            STOP: begin
                // Leaving at mid-stop-bit gives half a bit to catch the next
                // start edge of a back-to-back frame.
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        rx_data_nxt  = shreg;
                        rx_valid_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            WAIT_HIGH: begin
                // Break / stuck-low line: re-arm only after seeing it high.
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int HALF = CPB / 2;
    localparam int STOP_AGE = HALF + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works on the age (in cycles) of a frame since the idle cycle that saw
    // the synchronised line low: start check at HALF, data bit k at
    // HALF + (k+1)*CPB, stop at HALF + (DB+1)*CPB.
    typedef enum {M_IDLE, M_FRAME, M_WAIT} mmode_t;
    mmode_t        m_mode  = M_IDLE;
    int            m_age   = 0;
    logic          m_s1    = 1'b1;
    logic          m_rs    = 1'b1;
    logic [DB-1:0] m_word  = '0;
    logic [DB-1:0] m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_ferr  = 1'b0;

    initial begin
        logic line;
        forever begin
            @(posedge clk);
            line = m_rs;
            m_rs = m_s1;
            m_s1 = rx_in;
            if (rst) begin
                m_s1 = 1'b1; m_rs = 1'b1;
                m_mode = M_IDLE; m_data = '0; m_valid = 1'b0; m_ferr = 1'b0;
            end else begin
                m_valid = 1'b0;
                m_ferr  = 1'b0;
                case (m_mode)
                    M_IDLE: if (!line) begin m_mode = M_FRAME; m_age = 0; end
                    M_FRAME: begin
                        m_age++;
                        if (m_age == HALF) begin
                            if (line) m_mode = M_IDLE;
                        end else if (m_age == STOP_AGE) begin
                            if (line) begin
                                m_data = m_word; m_valid = 1'b1; m_mode = M_IDLE;
                            end else begin
                                m_ferr = 1'b1; m_mode = M_WAIT;
                            end
                        end else if ((m_age - HALF) % CPB == 0) begin
                            m_word[(m_age - HALF) / CPB - 1] = line;
                        end
                    end
                    M_WAIT: if (line) m_mode = M_IDLE;
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    logic          checking = 1'b0;
    logic          prev_valid = 1'b0;
    int            vcnt = 0;
    int            fcnt = 0;
    logic [DB-1:0] exp_q[$];

    initial begin
        logic [DB-1:0] e;
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("rx_data",   rx_data,   m_data);
                chk("rx_valid",  rx_valid,  m_valid);
                chk("frame_err", frame_err, m_ferr);
                chk("busy",      busy,      (m_mode != M_IDLE));
                if (rx_valid === 1'b1 && frame_err === 1'b1)
                    chk("valid_and_ferr", 1, 0);
                if (prev_valid)
                    chk("busy_after_valid", busy, 0);
                if (rx_valid === 1'b1) begin
                    vcnt++;
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("scoreboard_data", rx_data, e);
                    end
                end
                if (frame_err === 1'b1) fcnt++;
                prev_valid = (rx_valid === 1'b1);
            end
        end
    end

    // ---------------- serial line driver ----------------
    task automatic line_bit(input logic v);
        rx_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DB-1:0] b, input logic stop_bit);
        line_bit(1'b0);
        for (int i = 0; i < DB; i++) line_bit(b[i]);
        line_bit(stop_bit);
    endtask

    int v0, f0;
    logic [DB-1:0] r;
    logic [DB-1:0] ab;

    initial begin
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        chk("reset_rx_data",   rx_data,   0);
        chk("reset_rx_valid",  rx_valid,  0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_busy",      busy,      0);
        rst = 1'b0;
        idle(20);

        // single frame
        v0 = vcnt; f0 = fcnt;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        idle(CPB);
        chk("a5_pulses", vcnt - v0, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_model_pin", m_data, 8'hA5);
        chk("a5_no_ferr", fcnt - f0, 0);

        // short glitch rejected by the start check
        v0 = vcnt; f0 = fcnt;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle(2 * CPB);
        chk("glitch_no_valid", vcnt - v0, 0);
        chk("glitch_no_ferr", fcnt - f0, 0);
        chk("glitch_idle", busy, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        idle(CPB);
        chk("3c_data", rx_data, 8'h3C);

        // framing error with line held low
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        idle(CPB);
        v0 = vcnt; f0 = fcnt;
        send(8'h5A, 1'b0);
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
        chk("ferr_pulses", fcnt - f0, 1);
        chk("ferr_no_valid", vcnt - v0, 0);
        chk("ferr_data_held", rx_data, 8'h11);
        chk("ferr_waiting", busy, 1);
        chk("ferr_model_pin", m_mode == M_WAIT, 1);
        idle(2 * CPB);
        chk("ferr_rearmed", busy, 0);
        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b1);
        idle(CPB);
        chk("c3_data", rx_data, 8'hC3);

        // back-to-back frames
        v0 = vcnt; f0 = fcnt;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h81);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h81, 1'b1);
        idle(CPB);
        chk("b2b_pulses", vcnt - v0, 3);
        chk("b2b_last", rx_data, 8'h81);
        chk("b2b_no_ferr", fcnt - f0, 0);

        // reset in the middle of the data bits
        v0 = vcnt;
        ab = 8'h7E;
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(ab[i]);
        rx_in = ab[4];
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data",  rx_data,   0);
        chk("midrst_valid", rx_valid,  0);
        chk("midrst_ferr",  frame_err, 0);
        chk("midrst_busy",  busy,      0);
        rst = 1'b0;
        idle(3 * CPB);
        chk("midrst_no_valid", vcnt - v0, 0);
        exp_q.push_back(8'h42);
        send(8'h42, 1'b1);
        idle(CPB);
        chk("42_data", rx_data, 8'h42);

        // random loopback stream with small random phase gaps
        v0 = vcnt; f0 = fcnt;
        for (int n = 0; n < 256; n++) begin
            r = 8'($urandom);
            exp_q.push_back(r);
            send(r, 1'b1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
        end
        idle(2 * CPB);
        chk("loop_pulses", vcnt - v0, 256);
        chk("loop_no_ferr", fcnt - f0, 0);
        chk("loop_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
